// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and lane helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_MISALIGNED = 2'd1,
    CAUSE_ILLEGAL    = 2'd2,
    CAUSE_RANGE      = 2'd3
  } lsu_cause_e;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  // Byte lanes touched by an access of the given size at the given word offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] m;
    case (funct3[1:0])
      2'd0:    m = 4'b0001 << off;
      2'd1:    m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Encodings with no defined meaning for the access direction.
  function automatic logic is_illegal(input logic write, input logic [2:0] funct3);
    if (write) return (funct3 >= 3'd3);
    return (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    return ((funct3[1:0] == 2'd1) && off[0]) ||
           ((funct3[1:0] == 2'd2) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Lane extraction/extension for loads and read-modify-write merge for sub-word stores.
module load_store_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] store_word_c
);

  logic [XLEN-1:0] rshift_c;
  logic [XLEN-1:0] wshift_c;
  logic [3:0]      lanes_c;

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    rshift_c    = rdata >> {offset, 3'b000};
    load_data_c = rdata;
    case (funct3)
      LB:      load_data_c = {{24{rshift_c[7]}}, rshift_c[7:0]};
      LH:      load_data_c = {{16{rshift_c[15]}}, rshift_c[15:0]};
      LBU:     load_data_c = {24'h000000, rshift_c[7:0]};
      LHU:     load_data_c = {16'h0000, rshift_c[15:0]};
      default: load_data_c = rdata;
    endcase
  end

  // Replace only the written lanes; untouched lanes keep the memory contents.
  always_comb begin
    wshift_c     = wdata << {offset, 3'b000};
    lanes_c      = lane_mask(funct3, offset);
    store_word_c = rdata;
    for (int i = 0; i < 4; i++) begin
      if (lanes_c[i]) store_word_c[8*i +: 8] = wshift_c[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time between the execute stage and a word memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEMSIZE = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_base,
  input  logic [XLEN-1:0] req_offset,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  output logic [1:0]      resp_cause,
  output logic [3:0]      resp_rmask,
  output logic [3:0]      resp_wmask,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_value,
  output logic [2:0]      mem_funct3,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [XLEN-1:0] mem_data
);

  lsu_state_e      state, state_d;
  lsu_cause_e      acc_cause_c;
  logic [XLEN-1:0] ea_c;
  logic            latch_c;

  logic [XLEN-1:0] ea_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      funct3_q;
  logic            write_q;
  logic [3:0]      mask_c;

  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] store_word_c;

  logic            req_ready_d, resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
  logic [XLEN-1:0] resp_data_d, mem_addr_d, mem_value_d;
  logic [1:0]      resp_cause_d;
  logic [3:0]      resp_rmask_d, resp_wmask_d;
  logic [2:0]      mem_funct3_d;

  assign ea_c   = req_base + req_offset;
  assign mask_c = lane_mask(funct3_q, ea_q[1:0]);

  load_store_align u_align (
    .rdata        (mem_data),
    .wdata        (wdata_q),
    .offset       (ea_q[1:0]),
    .funct3       (funct3_q),
    .load_data_c  (load_data_c),
    .store_word_c (store_word_c)
  );

  // Fault classification of the presented request, highest priority first.
  always_comb begin
    acc_cause_c = CAUSE_NONE;
    if (is_illegal(req_write, req_funct3))              acc_cause_c = CAUSE_ILLEGAL;
    else if (is_misaligned(req_funct3, ea_c[1:0]))      acc_cause_c = CAUSE_MISALIGNED;
    else if (ea_c[XLEN-1:2] >= (XLEN-2)'(MEMSIZE))      acc_cause_c = CAUSE_RANGE;
  end

  // Next state and the registered output values that go with it.
  always_comb begin
    state_d      = state;
    latch_c      = 1'b0;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;
    resp_cause_d = 2'd0;
    resp_rmask_d = 4'd0;
    resp_wmask_d = 4'd0;
    mem_addr_d   = '0;
    mem_value_d  = '0;
    mem_funct3_d = 3'd0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          latch_c     = 1'b1;
          req_ready_d = 1'b0;
          if (acc_cause_c != CAUSE_NONE) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_cause_d = acc_cause_c;
          end else if (req_write && (req_funct3 == SW)) begin
            state_d      = S_WR;
            mem_write_d  = 1'b1;
            mem_addr_d   = {2'b00, ea_c[XLEN-1:2]};
            mem_value_d  = req_wdata;
            mem_funct3_d = LW;
          end else begin
            state_d      = S_RD;
            mem_read_d   = 1'b1;
            mem_addr_d   = {2'b00, ea_c[XLEN-1:2]};
            mem_funct3_d = LW;
          end
        end
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        if (write_q) begin
          state_d      = S_WR;
          mem_write_d  = 1'b1;
          mem_addr_d   = {2'b00, ea_q[XLEN-1:2]};
          mem_value_d  = store_word_c;
          mem_funct3_d = LW;
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = load_data_c;
          resp_rmask_d = mask_c;
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_wmask_d = mask_c;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
        end else begin
          resp_valid_d = resp_valid;
          resp_data_d  = resp_data;
          resp_err_d   = resp_err;
          resp_cause_d = resp_cause;
          resp_rmask_d = resp_rmask;
          resp_wmask_d = resp_wmask;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      resp_cause <= 2'd0;
      resp_rmask <= 4'd0;
      resp_wmask <= 4'd0;
      mem_addr   <= '0;
      mem_value  <= '0;
      mem_funct3 <= 3'd0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      state      <= state_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      resp_err   <= resp_err_d;
      resp_cause <= resp_cause_d;
      resp_rmask <= resp_rmask_d;
      resp_wmask <= resp_wmask_d;
      mem_addr   <= mem_addr_d;
      mem_value  <= mem_value_d;
      mem_funct3 <= mem_funct3_d;
      mem_read   <= mem_read_d;
      mem_write  <= mem_write_d;
    end
  end

  // Request fields captured on accept for use by the later states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ea_q     <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'd0;
      write_q  <= 1'b0;
    end else if (latch_c) begin
      ea_q     <= ea_c;
      wdata_q  <= req_wdata;
      funct3_q <= req_funct3;
      write_q  <= req_write;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed reference model.
module tb_load_store_unit;

  localparam int unsigned MEMSIZE = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_offset, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_data;
  logic [1:0]  resp_cause;
  logic [3:0]  resp_rmask, resp_wmask;
  logic [31:0] mem_addr, mem_value, mem_data;
  logic [2:0]  mem_funct3;
  logic        mem_read, mem_write;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEMSIZE(MEMSIZE)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .resp_cause (resp_cause),
    .resp_rmask (resp_rmask),
    .resp_wmask (resp_wmask),
    .mem_addr   (mem_addr),
    .mem_value  (mem_value),
    .mem_funct3 (mem_funct3),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_data   (mem_data)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'h11223344;
    if (i == 2) return 32'h12AB80CD;
    return {8'(i), 8'(i ^ 8'h5A), 8'hC3, 8'(255 - i)};
  endfunction

  // Downstream memory: read data appears the cycle after mem_read.
  logic [31:0] mem [MEMSIZE];
  logic        init_mem = 1'b1;
  int          wr_count = 0;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < int'(MEMSIZE); i++) mem[i] <= init_word(i);
      mem_data <= 32'h0;
    end else begin
      if (mem_read)  mem_data <= mem[mem_addr[5:0]];
      if (mem_write) begin
        mem[mem_addr[5:0]] <= mem_value;
        wr_count <= wr_count + 1;
      end
    end
  end

  // Reference model: memory as bytes, expectations in terms of latency from accept.
  logic [7:0]  ref_b [MEMSIZE*4];
  int          exp_lat, exp_rd_age, exp_wr_age;
  logic [31:0] exp_addr, exp_value, exp_data;
  logic        exp_err;
  logic [1:0]  exp_cause;
  logic [3:0]  exp_rmask, exp_wmask;

  task automatic model_access(input logic w, input logic [2:0] f3, input logic [31:0] ea,
                              input logic [31:0] wd);
    int          n;
    int unsigned lane;
    logic        ill, mis, rng;
    logic [31:0] val;
    logic [3:0]  m;
    n    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    lane = ea % 4;
    exp_lat = 1; exp_rd_age = 0; exp_wr_age = 0;
    exp_addr = 0; exp_value = 0; exp_data = 0; exp_err = 0; exp_cause = 0;
    exp_rmask = 0; exp_wmask = 0;
    ill = w ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7);
    mis = (ea % n) != 0;
    rng = (ea / 4) >= MEMSIZE;
    if (ill || mis || rng) begin
      exp_err   = 1'b1;
      exp_cause = ill ? 2'd2 : mis ? 2'd1 : 2'd3;
      return;
    end
    exp_addr = ea / 4;
    m = 4'((32'd1 << n) - 1) << lane;
    if (!w) begin
      exp_lat = 3; exp_rd_age = 1; exp_rmask = m;
      val = 0;
      for (int i = 0; i < n; i++) val = val | (32'(ref_b[ea + i]) << (8 * i));
      if (f3 < 4 && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8 * n)) - 1);
      exp_data = val;
    end else begin
      exp_wmask = m;
      for (int i = 0; i < n; i++) ref_b[ea + i] = 8'(wd >> (8 * i));
      for (int i = 0; i < 4; i++) exp_value[8*i +: 8] = ref_b[(ea & ~32'd3) + i];
      if (n == 4) begin exp_lat = 2; exp_wr_age = 1; end
      else begin exp_lat = 4; exp_rd_age = 1; exp_wr_age = 3; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks every cycle of a tracked access against the model.
  logic        pending = 1'b0;
  int          age = 0;
  logic [31:0] last_data, last_addr, last_value;
  logic [1:0]  last_cause;
  logic        last_err;
  logic [3:0]  last_rmask, last_wmask;
  always @(negedge clk) begin
    chk("rw_exclusive", 32'(mem_read && mem_write), 32'd0);
    if (pending) begin
      age++;
      chk("mem_read", 32'(mem_read), 32'(age == exp_rd_age));
      chk("mem_write", 32'(mem_write), 32'(age == exp_wr_age));
      if (mem_read || mem_write) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_funct3", 32'(mem_funct3), 32'd2);
        last_addr = mem_addr;
      end
      if (mem_write) begin
        chk("mem_value", mem_value, exp_value);
        last_value = mem_value;
      end
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      chk("resp_valid", 32'(resp_valid), 32'(age >= exp_lat));
      if (age >= exp_lat) begin
        chk("resp_data", resp_data, exp_data);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_cause", 32'(resp_cause), 32'(exp_cause));
        chk("resp_rmask", 32'(resp_rmask), 32'(exp_rmask));
        chk("resp_wmask", 32'(resp_wmask), 32'(exp_wmask));
        last_data = resp_data; last_err = resp_err; last_cause = resp_cause;
        last_rmask = resp_rmask; last_wmask = resp_wmask;
      end
    end
  end

  task automatic present(input logic w, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wd);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] base,
                     input logic [31:0] off, input logic [31:0] wd, input int hold);
    last_data = '1; last_addr = '1; last_value = '1; last_err = 1'bx;
    last_cause = 2'bxx; last_rmask = 4'hx; last_wmask = 4'hx;
    model_access(w, f3, base + off, wd);
    present(w, f3, base, off, wd);
    pending = 1'b1; age = 0;
    #1 req_valid = 1'b0;
    repeat (exp_lat + hold) @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0; pending = 1'b0;
    @(negedge clk);
    chk("resp_valid_clear", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    chk({tag, "_resp_err_cause"}, {29'd0, resp_err, resp_cause}, 32'd0);
    chk({tag, "_masks"}, {24'd0, resp_rmask, resp_wmask}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_value"}, mem_value, 32'd0);
    chk({tag, "_mem_ctl"}, {27'd0, mem_funct3, mem_read, mem_write}, 32'd0);
  endtask

  initial begin
    int wc0;
    for (int i = 0; i < int'(MEMSIZE); i++)
      for (int j = 0; j < 4; j++) ref_b[4*i + j] = 8'(init_word(i) >> (8 * j));
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_base = 0; req_offset = 0; req_wdata = 0; resp_ready = 1'b0;
    #1 chk_all_reset("reset");
    @(posedge clk); #1 init_mem = 1'b0;
    @(negedge clk); reset = 1'b0;

    // Loads of word 2 (0x12AB80CD) with each extension
    run(1'b0, 3'd0, 32'h8, 32'h1, 32'h0, 0);                 // LB ea 9
    chk("pin_lb_data", last_data, 32'hFFFFFF80);
    chk("pin_lb_addr", last_addr, 32'd2);
    chk("pin_lb_rmask", 32'(last_rmask), 32'h2);
    run(1'b0, 3'd4, 32'h8, 32'h1, 32'h0, 1);                 // LBU ea 9
    chk("pin_lbu_data", last_data, 32'h00000080);
    run(1'b0, 3'd1, 32'h8, 32'h0, 32'h0, 0);                 // LH ea 8
    chk("pin_lh_data", last_data, 32'hFFFF80CD);
    run(1'b0, 3'd5, 32'h20, 32'hFFFFFFEA, 32'h0, 0);         // LHU ea 0xA (negative offset)
    chk("pin_lhu_data", last_data, 32'h000012AB);

    // Halfword store into word 1 (0x11223344), then read back
    run(1'b1, 3'd1, 32'h6, 32'h0, 32'h1234BEEF, 0);          // SH ea 6
    chk("pin_sh_value", last_value, 32'hBEEF3344);
    chk("pin_sh_wmask", 32'(last_wmask), 32'hC);
    run(1'b0, 3'd2, 32'h4, 32'h0, 32'h0, 0);                 // LW ea 4

    // Faults and their priority
    run(1'b0, 3'd2, 32'h2, 32'h0, 32'h0, 0);                 // LW misaligned
    chk("pin_misaligned", {30'd0, last_cause}, 32'd1);
    run(1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 2);               // LW out of range
    chk("pin_range", {30'd0, last_cause}, 32'd3);
    run(1'b0, 3'd3, 32'h0, 32'h0, 32'h0, 0);                 // funct3 3 load
    chk("pin_illegal", {30'd0, last_cause}, 32'd2);
    run(1'b0, 3'd7, 32'h101, 32'h0, 32'h0, 0);               // illegal beats misaligned/range
    run(1'b1, 3'd3, 32'h10, 32'h0, 32'h0, 0);                // store funct3 3
    run(1'b1, 3'd1, 32'h101, 32'h0, 32'h0, 0);               // SH misaligned beats range
    run(1'b0, 3'd6, 32'h4, 32'h0, 32'h0, 0);                 // funct3 6 load

    // Word store with a stalled consumer
    wc0 = wr_count;
    run(1'b1, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 5);         // SW ea 0x10
    chk("pin_sw_value", last_value, 32'hDEADBEEF);
    chk("pin_sw_single_write", 32'(wr_count - wc0), 32'd1);
    run(1'b0, 3'd2, 32'h10, 32'h0, 32'h0, 0);

    // Address wrap-around and the last byte of memory
    run(1'b0, 3'd2, 32'hFFFFFFFC, 32'h8, 32'h0, 0);          // ea 4
    chk("pin_wrap_err", 32'(last_err), 32'd0);
    chk("pin_wrap_addr", last_addr, 32'd1);
    run(1'b1, 3'd0, 32'hFF, 32'h0, 32'h000000A7, 0);         // SB ea 0xFF
    run(1'b0, 3'd0, 32'hFF, 32'h0, 32'h0, 0);
    chk("pin_lastbyte", last_data, 32'hFFFFFFA7);
    run(1'b0, 3'd2, 32'hFC, 32'h4, 32'h0, 0);                // ea 0x100 out of range

    // Reset while a byte store is waiting on its read data
    present(1'b1, 3'd0, 32'h20, 32'h1, 32'h00000055);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_sb_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1 chk_all_reset("mid_reset");
    wc0 = wr_count;
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_no_write", 32'(wr_count - wc0), 32'd0);
    run(1'b0, 3'd2, 32'h20, 32'h0, 32'h0, 0);                // word 8 unchanged
    run(1'b1, 3'd0, 32'h20, 32'h1, 32'h00000055, 1);         // same SB now completes
    run(1'b0, 3'd4, 32'h21, 32'h0, 32'h0, 0);
    chk("pin_sb_after_reset", last_data, 32'h00000055);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
